// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: operation encoding and
// sizing helpers used by pc_unit and its return-address stack.
package pc_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_HOLD   = 3'd0,
    OP_INC    = 3'd1,
    OP_LOAD   = 3'd2,
    OP_BRANCH = 3'd3,
    OP_CALL   = 3'd4,
    OP_RET    = 3'd5
  } op_t;

  // Width needed to hold an occupancy count of 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push while full overwrites the oldest
// entry, and a pop while empty is ignored.
module pc_ras
  import pc_pkg::*;
#(
  parameter  int WIDTH     = 20,
  parameter  int RAS_DEPTH = 4,
  localparam int CNT_W     = cnt_width(RAS_DEPTH),
  localparam int PTR_W     = $clog2(RAS_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [WIDTH-1:0] mem_d [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] ptr_inc, ptr_dec;
  logic [CNT_W-1:0] count_q, count_d;

  // ptr_q is the next write slot; the top of stack sits one slot below it.
  always_comb begin
    ptr_inc = (ptr_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
    ptr_dec = (ptr_q == '0) ? PTR_W'(RAS_DEPTH - 1) : ptr_q - PTR_W'(1);
  end

  assign full  = (count_q == CNT_W'(RAS_DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign top   = mem_q[ptr_dec];

  always_comb begin
    mem_d   = mem_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    if (push) begin
      mem_d[ptr_q] = push_data;
      ptr_d        = ptr_inc;
      if (!full) begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (pop && !empty) begin
      ptr_d   = ptr_dec;
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC register, next-PC selection (hold/inc/load/branch/
// call/ret), return-address stack and sticky overflow/underflow flags.
module pc_unit
  import pc_pkg::*;
#(
  parameter  int               WIDTH     = 20,
  parameter  logic [WIDTH-1:0] RESET_VEC = '0,
  parameter  int unsigned      STEP      = 1,
  parameter  int               RAS_DEPTH = 4,
  localparam int               CNT_W     = cnt_width(RAS_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] offset,
  input  logic             err_clr,
  output logic [WIDTH-1:0] pc_out,
  output logic [CNT_W-1:0] ras_count,
  output logic             ras_full,
  output logic             ras_empty,
  output logic             ras_ovf,
  output logic             ras_unf
);

  localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] pc_inc, pc_br;
  logic [WIDTH-1:0] ras_top;
  logic             ras_push, ras_pop;
  op_t              op_sel;

  assign op_sel = op_t'(op);
  assign pc_inc = pc_q + STEP_V;
  assign pc_br  = pc_q + offset;

  // Flags clear first so that a same-cycle set takes priority over err_clr.
  always_comb begin
    pc_d     = pc_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    ovf_d    = ovf_q & ~err_clr;
    unf_d    = unf_q & ~err_clr;
    if (en) begin
      case (op_sel)
        OP_INC:    pc_d = pc_inc;
        OP_LOAD:   pc_d = target;
        OP_BRANCH: pc_d = pc_br;
        OP_CALL: begin
          ras_push = 1'b1;
          pc_d     = target;
          if (ras_full) begin
            ovf_d = 1'b1;
          end
        end
        OP_RET: begin
          if (ras_empty) begin
            pc_d  = pc_inc;
            unf_d = 1'b1;
          end else begin
            pc_d    = ras_top;
            ras_pop = 1'b1;
          end
        end
        default: pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q  <= RESET_VEC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_inc),
    .top       (ras_top),
    .count     (ras_count),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  assign pc_out  = pc_q;
  assign ras_ovf = ovf_q;
  assign ras_unf = unf_q;

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the CPU datapath; the next generation of the plain load-enable PC register. Holds the current instruction address, and each enabled cycle applies one operation: hold, increment, absolute load, relative branch, call or return. Calls and returns go through an internal return-address stack (RAS). Sits between the control unit (operation select) and instruction memory (address).

## Interface
Parameters:
- WIDTH, 20, PC/address width in bits (≥ 4)
- RESET_VEC, 0, PC value after reset (WIDTH bits)
- STEP, 1, increment applied by INC/CALL/empty-RET (< 2^WIDTH)
- RAS_DEPTH, 4, return-address stack entries (≥ 2)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  synchronous active-low reset
- en  in  1  advance enable; 0 = all state holds regardless of op
- op  in  3  operation: 0 HOLD, 1 INC, 2 LOAD, 3 BRANCH, 4 CALL, 5 RET, 6/7 reserved (treated as HOLD)
- target  in  WIDTH  absolute address for LOAD/CALL
- offset  in  WIDTH  two's-complement displacement for BRANCH
- err_clr  in  1  clears sticky error flags
- pc_out  out  WIDTH  current PC (registered)
- ras_count  out  clog2(RAS_DEPTH+1)  valid RAS entries
- ras_full  out  1  ras_count == RAS_DEPTH
- ras_empty  out  1  ras_count == 0
- ras_ovf  out  1  sticky: CALL was issued while full
- ras_unf  out  1  sticky: RET was issued while empty

## Operation
- Reset (rst_n=0 at the edge): pc_out=RESET_VEC, ras_count=0, ras_ovf=ras_unf=0, RAS storage zeroed. Reset overrides en/op/err_clr.
- en=0: pc, RAS and flags hold. err_clr still acts.
- HOLD / reserved: no change.
- INC: pc ← (pc + STEP) mod 2^WIDTH.
- LOAD: pc ← target.
- BRANCH: pc ← (pc + offset) mod 2^WIDTH. The offset is sign-interpreted, so the sum wraps in both directions.
- CALL: push (pc + STEP) mod 2^WIDTH, then pc ← target.
  - Not full: ras_count increments.
  - Full: the oldest entry is discarded (circular overwrite), ras_count stays RAS_DEPTH, ras_ovf ← 1.
- RET:
  - Not empty: pc ← top entry, pop, ras_count decrements.
  - Empty: pc ← (pc + STEP) mod 2^WIDTH, ras_count stays 0, ras_unf ← 1.
- err_clr=1 clears ras_ovf/ras_unf. If a flag is set and cleared in the same cycle, the set wins.
- ras_full and ras_empty are combinational decodes of the registered ras_count.

## Timing
- Single clock domain. All outputs are registered or decoded from registers, and nothing depends combinationally on inputs.
- Latency is one cycle: the op sampled at edge N is visible on pc_out and the flags after edge N.
- One operation per cycle. Back-to-back CALL/RET at full rate are supported, and RET immediately after CALL returns the just-pushed address.
- Reset asserted mid-sequence discards all RAS contents on that edge. The first op is accepted at the first edge with rst_n=1.

## Structure
- Package pc_pkg:
  - op_t enum (HOLD, INC, LOAD, BRANCH, CALL, RET)
  - op width constant
  - clog2-based count-width function
- Sub-module pc_ras holds the circular return-address stack.
  - Parameters: WIDTH, RAS_DEPTH.
  - Ports: clk, rst_n, push, pop, push_data, top, count, full, empty.
  - Push while full overwrites the oldest entry.
  - Pop while empty is ignored.
- pc_unit contains the PC register, next-PC mux/adders and the sticky flags.

## Test plan
All scenarios use WIDTH=20, STEP=1, RAS_DEPTH=4, RESET_VEC=0.
- Reset, then INC ×3 → pc_out 0x00000, 0x00001, 0x00002, 0x00003. ras_empty=1, flags 0.
- LOAD target 0xFFFFF, then INC → pc_out 0xFFFFF, then 0x00000 (wrap). BRANCH offset 0xFFFFC (−4) from 0x00010 → 0x0000C.
- From pc 0x00100: CALL 0x00200, CALL 0x00300, RET, RET → pc 0x00200, 0x00300, 0x00201, 0x00101. ras_count goes 1, 2, 1, 0.
- Five CALLs to 0x01000..0x05000 starting at pc 0x00000 → ras_ovf=1, ras_count=4. Four RETs return 0x04001, 0x03001, 0x02001, 0x01001. A fifth RET gives pc 0x01002 and ras_unf=1.
- en=0 with op=CALL and op=RET held for 3 cycles → pc, ras_count and flags unchanged. err_clr=1 together with an empty RET → ras_unf stays 1; err_clr alone next cycle → 0.
- Reset asserted with ras_count=3 → next cycle pc_out=0x00000, ras_count=0, and a following RET sets ras_unf.
